// File: rtl/regwrite_arbiter_pkg.sv
// Shared register-file writeback types and widths.
package regfile_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  // Writeback request as produced by the execute and load stages.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // Identity of the requester that most recently won the write port.
  typedef enum logic {
    GNT_REQ0 = 1'b0,
    GNT_REQ1 = 1'b1
  } grant_t;

endpackage

// File: rtl/regwrite_arbiter_if.sv
// Writeback request, register-file write and forwarding signals.
interface regwrite_arbiter_if
  import regfile_pkg::*;
#(
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int CNT_W  = regfile_pkg::CNT_W
);

  logic              freeze;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              RegWrite;
  logic [ADDR_W-1:0] write_register;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] raddrA;
  logic [ADDR_W-1:0] raddrB;
  logic              fwd_validA;
  logic [DATA_W-1:0] fwd_dataA;
  logic              fwd_validB;
  logic [DATA_W-1:0] fwd_dataB;
  logic [CNT_W-1:0]  grant_cnt0;
  logic [CNT_W-1:0]  grant_cnt1;

  // Pipeline / decoder side: drives requests and read addresses.
  modport master (
    output freeze,
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output raddrA, raddrB,
    input  req0_ready, req1_ready,
    input  RegWrite, write_register, data_in,
    input  fwd_validA, fwd_dataA, fwd_validB, fwd_dataB,
    input  grant_cnt0, grant_cnt1
  );

  // Arbiter side.
  modport slave (
    input  freeze,
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  raddrA, raddrB,
    output req0_ready, req1_ready,
    output RegWrite, write_register, data_in,
    output fwd_validA, fwd_dataA, fwd_validB, fwd_dataB,
    output grant_cnt0, grant_cnt1
  );

endinterface

// File: rtl/regwrite_arbiter_rr.sv
// Two-way round-robin grant with freeze/reset gating.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_freeze,
  input  logic i_valid0,
  input  logic i_valid1,
  output logic o_grant0,
  output logic o_grant1
);

  grant_t r_last_grant;
  logic   w_block;

  // Remember the most recent winner; a grant always completes a handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= GNT_REQ1;
    end else if (o_grant0) begin
      r_last_grant <= GNT_REQ0;
    end else if (o_grant1) begin
      r_last_grant <= GNT_REQ1;
    end
  end

  // Lone requester wins; on contention the one that did not win last time.
  always_comb begin
    o_grant0 = 1'b0;
    o_grant1 = 1'b0;
    w_block  = reset || i_freeze;
    if (!w_block) begin
      o_grant0 = i_valid0 && (!i_valid1 || (r_last_grant == GNT_REQ1));
      o_grant1 = i_valid1 && (!i_valid0 || (r_last_grant == GNT_REQ0));
    end
  end

endmodule

// File: rtl/regwrite_arbiter.sv
// Register-file write-port arbiter: ALU (req0) vs load (req1) writeback,
// registered write stage, read-after-write forwarding, grant counters.
module regwrite_arbiter
  import regfile_pkg::*;
#(
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int CNT_W  = regfile_pkg::CNT_W
)(
  input  logic              clk,
  input  logic              reset,
  regwrite_arbiter_if.slave bus
);

  logic              w_grant0;
  logic              w_grant1;
  logic              w_regwrite;
  logic              w_fwd_validA;
  logic              w_fwd_validB;
  logic              r_regwrite;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [CNT_W-1:0]  r_cnt0;
  logic [CNT_W-1:0]  r_cnt1;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .i_freeze (bus.freeze),
    .i_valid0 (bus.req0_valid),
    .i_valid1 (bus.req1_valid),
    .o_grant0 (w_grant0),
    .o_grant1 (w_grant1)
  );

  // Output stage: capture the winner; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_regwrite <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_regwrite <= w_grant0 || w_grant1;
      if (w_grant0) begin
        r_wr_addr <= bus.req0_addr;
        r_wr_data <= bus.req0_data;
      end else if (w_grant1) begin
        r_wr_addr <= bus.req1_addr;
        r_wr_data <= bus.req1_data;
      end
    end
  end

  // Saturating grant counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_grant0 && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + CNT_W'(1);
      if (w_grant1 && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + CNT_W'(1);
    end
  end

  // Write enable is masked by reset so an entry held in the stage when
  // reset arrives never reaches reg_file; forwarding follows the masked enable.
  always_comb begin
    w_regwrite   = r_regwrite && !reset;
    w_fwd_validA = w_regwrite && (r_wr_addr == bus.raddrA);
    w_fwd_validB = w_regwrite && (r_wr_addr == bus.raddrB);
  end

  assign bus.req0_ready     = w_grant0;
  assign bus.req1_ready     = w_grant1;
  assign bus.RegWrite       = w_regwrite;
  assign bus.write_register = r_wr_addr;
  assign bus.data_in        = r_wr_data;
  assign bus.fwd_validA     = w_fwd_validA;
  assign bus.fwd_dataA      = w_fwd_validA ? r_wr_data : '0;
  assign bus.fwd_validB     = w_fwd_validB;
  assign bus.fwd_dataB      = w_fwd_validB ? r_wr_data : '0;
  assign bus.grant_cnt0     = r_cnt0;
  assign bus.grant_cnt1     = r_cnt1;

endmodule
